// File: rtl/cpu_trace_emitter.sv
// Serialises CPU write-back records into an ASCII trace stream, one character per cycle.
// Decimal fields are converted when a record is accepted and held MS-digit-first for emission.
module cpu_trace_emitter (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_type,
   input  logic [15:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_grf,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char,
   output logic        char_valid,
   output logic        char_last,
   output logic [15:0] rec_count
);

   localparam int unsigned TIME_W  = 16;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TDIG_W  = 3;
   localparam int unsigned GDIG_W  = 2;
   localparam logic [TIME_W-1:0] TIME_MAX = 16'd9999;

   typedef enum logic [3:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP0, S_SIGIL,
      S_FIELD, S_SP1, S_LT, S_EQ, S_SP2, S_DATA, S_HASH
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                type_q;
   logic [TIME_W-1:0]   tdig_q, tdig_d;
   logic [TDIG_W-1:0]   tn_q, tn_d;
   logic [7:0]          gdig_q, gdig_d;
   logic [GDIG_W-1:0]   gn_q, gn_d;
   logic [WORD_W-1:0]   pc_q, addr_q, data_q;
   logic [7:0]          char_d;
   logic                accept_c;
   logic                field_last_c;
   logic [TIME_W-1:0]   tsat_c, tdec_c;
   logic [3:0]          gten_c, gone_c;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h57 + 8'(nib));
   endfunction

   function automatic logic [3:0] nibble(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] i);
      logic [4:0] sh;
      sh = {3'd7 - i, 2'b00};
      return w[sh +: 4];
   endfunction

   assign accept_c = in_valid & in_ready;

   // Saturate and split the cycle time / register number into MS-first decimal digits
   always_comb begin
      tsat_c = (in_time > TIME_MAX) ? TIME_MAX : in_time;
      tdec_c = {4'(tsat_c / 16'd1000), 4'((tsat_c / 16'd100) % 16'd10),
                4'((tsat_c / 16'd10) % 16'd10), 4'(tsat_c % 16'd10)};
      if (tsat_c >= 16'd1000)     tn_d = 3'd4;
      else if (tsat_c >= 16'd100) tn_d = 3'd3;
      else if (tsat_c >= 16'd10)  tn_d = 3'd2;
      else                        tn_d = 3'd1;
      tdig_d = tdec_c << {3'd4 - tn_d, 2'b00};
      gten_c = 4'(in_grf / 5'd10);
      gone_c = 4'(in_grf % 5'd10);
      if (in_grf >= 5'd10) begin
         gn_d   = 2'd2;
         gdig_d = {gten_c, gone_c};
      end else begin
         gn_d   = 2'd1;
         gdig_d = {gone_c, 4'h0};
      end
   end

   assign field_last_c = type_q ? (idx_q == 3'd7) : (idx_q == (3'(gn_q) - 3'd1));

   // Next state: state_q names the character currently on the outputs
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      char_d  = 8'h00;
      case (state_q)
         S_IDLE:  if (accept_c) state_d = S_CARET;
         S_CARET: begin state_d = S_TIME; idx_d = '0; end
         S_TIME: begin
            if (idx_q == (tn_q - 3'd1)) begin state_d = S_AT; idx_d = '0; end
            else idx_d = idx_q + 3'd1;
         end
         S_AT:    begin state_d = S_PC; idx_d = '0; end
         S_PC: begin
            if (idx_q == 3'd7) begin state_d = S_COLON; idx_d = '0; end
            else idx_d = idx_q + 3'd1;
         end
         S_COLON: state_d = S_SP0;
         S_SP0:   state_d = S_SIGIL;
         S_SIGIL: begin state_d = S_FIELD; idx_d = '0; end
         S_FIELD: begin
            if (field_last_c) begin state_d = S_SP1; idx_d = '0; end
            else idx_d = idx_q + 3'd1;
         end
         S_SP1:   state_d = S_LT;
         S_LT:    state_d = S_EQ;
         S_EQ:    state_d = S_SP2;
         S_SP2:   begin state_d = S_DATA; idx_d = '0; end
         S_DATA: begin
            if (idx_q == 3'd7) begin state_d = S_HASH; idx_d = '0; end
            else idx_d = idx_q + 3'd1;
         end
         S_HASH:  state_d = accept_c ? S_CARET : S_IDLE;
         default: begin state_d = S_IDLE; idx_d = '0; end
      endcase

      case (state_d)
         S_CARET: char_d = "^";
         S_TIME:  char_d = 8'h30 + 8'(tdig_q[{~idx_d[1:0], 2'b00} +: 4]);
         S_AT:    char_d = "@";
         S_PC:    char_d = hex_char(nibble(pc_q, idx_d));
         S_COLON: char_d = ":";
         S_SP0, S_SP1, S_SP2: char_d = " ";
         S_SIGIL: char_d = type_q ? "*" : "$";
         S_FIELD: char_d = type_q ? hex_char(nibble(addr_q, idx_d))
                                  : 8'h30 + 8'(gdig_q[{~idx_d[0], 2'b00} +: 4]);
         S_LT:    char_d = "<";
         S_EQ:    char_d = "=";
         S_DATA:  char_d = hex_char(nibble(data_q, idx_d));
         S_HASH:  char_d = "#";
         default: char_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         char       <= 8'h00;
         char_valid <= 1'b0;
         char_last  <= 1'b0;
         in_ready   <= 1'b1;
         rec_count  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         char       <= char_d;
         char_valid <= (state_d != S_IDLE);
         char_last  <= (state_d == S_HASH);
         in_ready   <= (state_d == S_IDLE) || (state_d == S_HASH);
         if (char_last) rec_count <= rec_count + 16'd1;
      end
   end

   // Record fields, captured only on the accept edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         type_q <= 1'b0;
         tdig_q <= '0;
         tn_q   <= 3'd1;
         gdig_q <= '0;
         gn_q   <= 2'd1;
         pc_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else if (accept_c) begin
         type_q <= in_type;
         tdig_q <= tdig_d;
         tn_q   <= tn_d;
         gdig_q <= gdig_d;
         gn_q   <= gn_d;
         pc_q   <= in_pc;
         addr_q <= in_addr;
         data_q <= in_data;
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: a string-level model of the trace stream checked every cycle,
// plus literal expectations for complete records.
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_type = 1'b0;
   logic [15:0] in_time = '0;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_grf = '0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic [7:0]  char;
   logic        char_valid;
   logic        char_last;
   logic [15:0] rec_count;

   int checks = 0;
   int errors = 0;

   cpu_trace_emitter dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_time(in_time), .in_pc(in_pc), .in_grf(in_grf),
      .in_addr(in_addr), .in_data(in_data), .char(char), .char_valid(char_valid),
      .char_last(char_last), .rec_count(rec_count)
   );

   always #5 clk = ~clk;

   // Model: a queue of characters still to appear, and the one currently expected
   byte         exp_q[$];
   logic        cur_v = 1'b0;
   logic [7:0]  cur_c = 8'h00;
   logic [15:0] m_count = '0;
   logic        acc_next = 1'b0;
   string       got_str = "";
   string       last_rec = "";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   function automatic string rec_str(input logic typ, input logic [15:0] t, input logic [31:0] pc,
                                     input logic [4:0] grf, input logic [31:0] addr,
                                     input logic [31:0] data);
      int ts;
      ts = (t > 16'd9999) ? 9999 : int'(t);
      if (typ) return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, addr, data);
      else     return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, grf, data);
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         cur_v    = 1'b0;
         cur_c    = 8'h00;
         m_count  = '0;
         acc_next = 1'b0;
         got_str  = "";
      end else begin
         logic  m_ready;
         string s;
         chk("char_valid", 32'(char_valid), 32'(cur_v));
         chk("char", 32'(char), 32'(cur_c));
         chk("char_last", 32'(char_last), 32'(cur_v && cur_c == "#"));
         chk("rec_count", 32'(rec_count), 32'(m_count));
         m_ready = !cur_v || (cur_c == "#");
         chk("in_ready", 32'(in_ready), 32'(m_ready));
         if (char_valid) got_str = $sformatf("%s%c", got_str, char);
         if (char_last) begin
            last_rec = got_str;
            got_str  = "";
         end
         acc_next = in_valid && m_ready;
         if (acc_next) begin
            s = rec_str(in_type, in_time, in_pc, in_grf, in_addr, in_data);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
         end
         if (cur_v && cur_c == "#") m_count = m_count + 16'd1;
         if (exp_q.size() > 0) begin
            cur_v = 1'b1;
            cur_c = exp_q.pop_front();
         end else begin
            cur_v = 1'b0;
            cur_c = 8'h00;
         end
      end
   end

   // Present a record and hold it until the accept edge; returns #1 after that edge
   task automatic send(input logic typ, input logic [15:0] t, input logic [31:0] pc,
                       input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data);
      int n;
      in_type = typ; in_time = t; in_pc = pc; in_grf = grf; in_addr = addr; in_data = data;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!acc_next && n < 200);
      if (!acc_next) chk("accept_timeout", 32'(n), 32'd0);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      in_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while ((cur_v || exp_q.size() > 0) && n < 200);
      if (cur_v || exp_q.size() > 0) chk("idle_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      string s;
      #1 reset = 1'b0;
      #1;
      chk("rst_char", 32'(char), 32'h0);
      chk("rst_char_valid", 32'(char_valid), 32'h0);
      chk("rst_char_last", 32'(char_last), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_rec_count", 32'(rec_count), 32'h0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Model pins
      s = rec_str(1'b0, 16'd10, 32'h3000, 5'd1, 32'h0, 32'h0000abcd);
      chk_str("model_reg", s, "^10@00003000: $1 <= 0000abcd#");
      chk("model_reg_len", 32'(s.len()), 32'd29);
      s = rec_str(1'b1, 16'd0, 32'h3004, 5'd0, 32'h10, 32'hffffffff);
      chk("model_mem_len", 32'(s.len()), 32'd35);

      // Register record
      send(1'b0, 16'd10, 32'h3000, 5'd1, 32'h0, 32'h0000abcd);
      wait_idle();
      chk_str("reg_rec", last_rec, "^10@00003000: $1 <= 0000abcd#");
      chk("reg_len", 32'(last_rec.len()), 32'd29);
      chk("reg_count", 32'(rec_count), 32'd1);

      // Memory record
      send(1'b1, 16'd0, 32'h00003004, 5'd7, 32'h10, 32'hffffffff);
      wait_idle();
      chk_str("mem_rec", last_rec, "^0@00003004: *00000010 <= ffffffff#");
      chk("mem_len", 32'(last_rec.len()), 32'd35);

      // Saturated time, two-digit register
      send(1'b0, 16'd12345, 32'hdeadbeef, 5'd31, 32'h0, 32'h1234abcd);
      wait_idle();
      chk_str("sat_rec", last_rec, "^9999@deadbeef: $31 <= 1234abcd#");
      chk("sat_count", 32'(rec_count), 32'd3);

      // Back to back, in_valid held high throughout
      send(1'b0, 16'd9999, 32'h100, 5'd9, 32'h0, 32'h0);
      send(1'b1, 16'd100, 32'h104, 5'd0, 32'hcafef00d, 32'h89abcdef);
      wait_idle();
      chk_str("b2b_rec2", last_rec, "^100@00000104: *cafef00d <= 89abcdef#");
      chk("b2b_count", 32'(rec_count), 32'd5);

      // Reset during the PC field
      send(1'b0, 16'd10, 32'h3000, 5'd1, 32'h0, 32'h0000abcd);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_char", 32'(char), 32'h0);
      chk("mid_char_valid", 32'(char_valid), 32'h0);
      chk("mid_in_ready", 32'(in_ready), 32'h1);
      chk("mid_rec_count", 32'(rec_count), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      send(1'b1, 16'd1000, 32'h2000, 5'd0, 32'h20, 32'h5);
      wait_idle();
      chk_str("post_rst_rec", last_rec, "^1000@00002000: *00000020 <= 00000005#");
      chk("post_rst_count", 32'(rec_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
